// File: rtl/issue_station.sv
// Out-of-order issue buffer: holds ALU ops, captures broadcast results, issues the oldest ready entry.
// Latency: insert-to-issue 1 cycle with ready or bypassed operands; broadcast wakeup is registered.
// Backpressure: issue_ready low keeps the selected entry present; dec_full drops further inserts.
module issue_station #(
    parameter int DEPTH      = 8,
    parameter int ROB_WIDTH  = 4,
    parameter int TYPE_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BCAST  = 2
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            flush,
    input  logic                            dec_valid,
    output logic                            dec_full,
    input  logic [TYPE_WIDTH-1:0]           dec_type,
    input  logic [DATA_WIDTH-1:0]           dec_data_j,
    input  logic [DATA_WIDTH-1:0]           dec_data_k,
    input  logic                            dec_pending_j,
    input  logic                            dec_pending_k,
    input  logic [ROB_WIDTH-1:0]            dec_dep_j,
    input  logic [ROB_WIDTH-1:0]            dec_dep_k,
    input  logic [ROB_WIDTH-1:0]            dec_rob_id,
    input  logic [DATA_WIDTH-1:0]           dec_imm,
    input  logic [NUM_BCAST-1:0]            bc_en,
    input  logic [NUM_BCAST*ROB_WIDTH-1:0]  bc_rob_id,
    input  logic [NUM_BCAST*DATA_WIDTH-1:0] bc_data,
    output logic                            issue_valid,
    input  logic                            issue_ready,
    output logic [TYPE_WIDTH-1:0]           issue_type,
    output logic [ROB_WIDTH-1:0]            issue_rob_id,
    output logic [DATA_WIDTH-1:0]           issue_data_j,
    output logic [DATA_WIDTH-1:0]           issue_data_k,
    output logic [DATA_WIDTH-1:0]           issue_imm,
    output logic [$clog2(DEPTH):0]          count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int BC_W  = DATA_WIDTH + 1;

    // Per-entry state
    logic                  present_q [DEPTH];
    logic [TYPE_WIDTH-1:0] op_type_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_j_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_k_q  [DEPTH];
    logic                  pend_j_q  [DEPTH];
    logic                  pend_k_q  [DEPTH];
    logic [ROB_WIDTH-1:0]  dep_j_q   [DEPTH];
    logic [ROB_WIDTH-1:0]  dep_k_q   [DEPTH];
    logic [ROB_WIDTH-1:0]  rob_q     [DEPTH];
    logic [DATA_WIDTH-1:0] imm_q     [DEPTH];
    logic [IDX_W-1:0]      age_q     [DEPTH];

    // {hit, data} per operand; lowest matching port wins
    logic [BC_W-1:0] wk_j [DEPTH];
    logic [BC_W-1:0] wk_k [DEPTH];
    logic [BC_W-1:0] dec_wk_j;
    logic [BC_W-1:0] dec_wk_k;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] sel_age;
    logic [IDX_W-1:0] free_idx;
    logic             do_insert;
    logic             do_issue;

    function automatic logic [BC_W-1:0] bc_lookup(
        input logic [ROB_WIDTH-1:0]            dep,
        input logic [NUM_BCAST-1:0]            en,
        input logic [NUM_BCAST*ROB_WIDTH-1:0]  tags,
        input logic [NUM_BCAST*DATA_WIDTH-1:0] dats
    );
        logic [BC_W-1:0] r;
        r = '0;
        // Scan high to low so the lowest matching port is the last written
        for (int p = NUM_BCAST - 1; p >= 0; p--) begin
            if (en[p] && (tags[p*ROB_WIDTH +: ROB_WIDTH] == dep)) begin
                r = {1'b1, dats[p*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
        return r;
    endfunction

    // Broadcast tag match for every stored operand and for the incoming op
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk_j[i] = bc_lookup(dep_j_q[i], bc_en, bc_rob_id, bc_data);
            wk_k[i] = bc_lookup(dep_k_q[i], bc_en, bc_rob_id, bc_data);
        end
        dec_wk_j = bc_lookup(dec_dep_j, bc_en, bc_rob_id, bc_data);
        dec_wk_k = bc_lookup(dec_dep_k, bc_en, bc_rob_id, bc_data);
    end

    // Pick the ready entry with the highest age (the oldest)
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (present_q[i] && !pend_j_q[i] && !pend_k_q[i] &&
                (!sel_found || (age_q[i] > sel_age))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age_q[i];
            end
        end
    end

    // Lowest-index empty slot receives the next insert
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!present_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign dec_full    = (count == CNT_W'(DEPTH));
    assign issue_valid = sel_found && rdy_in && !flush;
    assign do_insert   = dec_valid && !dec_full && rdy_in && !flush;
    assign do_issue    = issue_valid && issue_ready;

    // Present the selected entry's fields; zero when nothing is issuable
    always_comb begin
        issue_type   = '0;
        issue_rob_id = '0;
        issue_data_j = '0;
        issue_data_k = '0;
        issue_imm    = '0;
        if (issue_valid) begin
            issue_type   = op_type_q[sel_idx];
            issue_rob_id = rob_q[sel_idx];
            issue_data_j = data_j_q[sel_idx];
            issue_data_k = data_k_q[sel_idx];
            issue_imm    = imm_q[sel_idx];
        end
    end

    // Entry state: flush beats everything; otherwise wakeup, issue, age shift and insert together
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                present_q[i] <= 1'b0;
                op_type_q[i] <= '0;
                data_j_q[i]  <= '0;
                data_k_q[i]  <= '0;
                pend_j_q[i]  <= 1'b0;
                pend_k_q[i]  <= 1'b0;
                dep_j_q[i]   <= '0;
                dep_k_q[i]   <= '0;
                rob_q[i]     <= '0;
                imm_q[i]     <= '0;
                age_q[i]     <= '0;
            end
        end else if (rdy_in) begin
            if (flush) begin
                count <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    present_q[i] <= 1'b0;
                end
            end else begin
                count <= count + CNT_W'(do_insert) - CNT_W'(do_issue);
                for (int i = 0; i < DEPTH; i++) begin
                    if (present_q[i]) begin
                        if (pend_j_q[i] && wk_j[i][DATA_WIDTH]) begin
                            data_j_q[i] <= wk_j[i][DATA_WIDTH-1:0];
                            pend_j_q[i] <= 1'b0;
                        end
                        if (pend_k_q[i] && wk_k[i][DATA_WIDTH]) begin
                            data_k_q[i] <= wk_k[i][DATA_WIDTH-1:0];
                            pend_k_q[i] <= 1'b0;
                        end
                        if (do_issue && (IDX_W'(i) == sel_idx)) begin
                            present_q[i] <= 1'b0;
                        end else begin
                            // Younger than the issued entry keeps its rank; older ones close the gap
                            age_q[i] <= age_q[i] + IDX_W'(do_insert)
                                        - IDX_W'(do_issue && (age_q[i] > sel_age));
                        end
                    end
                    if (do_insert && (IDX_W'(i) == free_idx)) begin
                        present_q[i] <= 1'b1;
                        op_type_q[i] <= dec_type;
                        dep_j_q[i]   <= dec_dep_j;
                        dep_k_q[i]   <= dec_dep_k;
                        rob_q[i]     <= dec_rob_id;
                        imm_q[i]     <= dec_imm;
                        age_q[i]     <= '0;
                        if (dec_pending_j && dec_wk_j[DATA_WIDTH]) begin
                            data_j_q[i] <= dec_wk_j[DATA_WIDTH-1:0];
                            pend_j_q[i] <= 1'b0;
                        end else begin
                            data_j_q[i] <= dec_data_j;
                            pend_j_q[i] <= dec_pending_j;
                        end
                        if (dec_pending_k && dec_wk_k[DATA_WIDTH]) begin
                            data_k_q[i] <= dec_wk_k[DATA_WIDTH-1:0];
                            pend_k_q[i] <= 1'b0;
                        end else begin
                            data_k_q[i] <= dec_data_k;
                            pend_k_q[i] <= dec_pending_k;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_station.sv
// Bench for issue_station: insertion-ordered queue model checked every cycle, plus literal issue-order checks.
// Latency: model updates on the rising edge, comparisons on the falling edge.
// Backpressure: issue_ready is driven per scenario to hold or drain entries.
module tb_issue_station;

    localparam int DEPTH = 8;
    localparam int RW    = 4;
    localparam int TW    = 5;
    localparam int DW    = 32;
    localparam int NB    = 2;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in;
    logic              flush;
    logic              dec_valid;
    logic              dec_full;
    logic [TW-1:0]     dec_type;
    logic [DW-1:0]     dec_data_j, dec_data_k;
    logic              dec_pending_j, dec_pending_k;
    logic [RW-1:0]     dec_dep_j, dec_dep_k;
    logic [RW-1:0]     dec_rob_id;
    logic [DW-1:0]     dec_imm;
    logic [NB-1:0]     bc_en;
    logic [NB*RW-1:0]  bc_rob_id;
    logic [NB*DW-1:0]  bc_data;
    logic              issue_valid;
    logic              issue_ready;
    logic [TW-1:0]     issue_type;
    logic [RW-1:0]     issue_rob_id;
    logic [DW-1:0]     issue_data_j, issue_data_k, issue_imm;
    logic [$clog2(DEPTH):0] count;

    issue_station #(
        .DEPTH(DEPTH), .ROB_WIDTH(RW), .TYPE_WIDTH(TW), .DATA_WIDTH(DW), .NUM_BCAST(NB)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .dec_valid(dec_valid), .dec_full(dec_full), .dec_type(dec_type),
        .dec_data_j(dec_data_j), .dec_data_k(dec_data_k),
        .dec_pending_j(dec_pending_j), .dec_pending_k(dec_pending_k),
        .dec_dep_j(dec_dep_j), .dec_dep_k(dec_dep_k),
        .dec_rob_id(dec_rob_id), .dec_imm(dec_imm),
        .bc_en(bc_en), .bc_rob_id(bc_rob_id), .bc_data(bc_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_type(issue_type), .issue_rob_id(issue_rob_id),
        .issue_data_j(issue_data_j), .issue_data_k(issue_data_k),
        .issue_imm(issue_imm), .count(count)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: entries kept oldest-first in insertion order
    typedef struct {
        logic [TW-1:0] typ;
        logic [DW-1:0] dj, dk, imm;
        logic          pj, pk;
        logic [RW-1:0] depj, depk, rob;
    } ent_t;

    ent_t mq[$];
    ent_t m_e;
    int   m_s;
    logic m_full;
    logic [DW-1:0] m_d;

    function automatic int m_sel();
        for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].pj && !mq[i].pk) return i;
        end
        return -1;
    endfunction

    function automatic logic m_bc(input logic [RW-1:0] dep, output logic [DW-1:0] d);
        d = '0;
        for (int p = 0; p < NB; p++) begin
            if (bc_en[p] && (bc_rob_id[p*RW +: RW] == dep)) begin
                d = bc_data[p*DW +: DW];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Model update at each rising edge (and on asynchronous reset)
    initial forever begin
        @(posedge clk_in or negedge rst_in);
        if (!rst_in) begin
            mq.delete();
        end else if (rdy_in) begin
            if (flush) begin
                mq.delete();
            end else begin
                m_full = (mq.size() == DEPTH);
                m_s = m_sel();
                if (m_s >= 0 && issue_ready) mq.delete(m_s);
                foreach (mq[i]) begin
                    if (mq[i].pj && m_bc(mq[i].depj, m_d)) begin mq[i].dj = m_d; mq[i].pj = 1'b0; end
                    if (mq[i].pk && m_bc(mq[i].depk, m_d)) begin mq[i].dk = m_d; mq[i].pk = 1'b0; end
                end
                if (dec_valid && !m_full) begin
                    m_e.typ = dec_type; m_e.imm = dec_imm; m_e.rob = dec_rob_id;
                    m_e.depj = dec_dep_j; m_e.depk = dec_dep_k;
                    if (dec_pending_j && m_bc(dec_dep_j, m_d)) begin m_e.dj = m_d; m_e.pj = 1'b0; end
                    else begin m_e.dj = dec_data_j; m_e.pj = dec_pending_j; end
                    if (dec_pending_k && m_bc(dec_dep_k, m_d)) begin m_e.dk = m_d; m_e.pk = 1'b0; end
                    else begin m_e.dk = dec_data_k; m_e.pk = dec_pending_k; end
                    mq.push_back(m_e);
                end
            end
        end
    end

    // Issue log of handshakes, for literal order checks
    logic [RW-1:0] lg_rob[$];
    logic [DW-1:0] lg_dj[$];
    logic [DW-1:0] lg_dk[$];

    function automatic logic [31:0] lg_rob_at(input int i);
        if (i < lg_rob.size()) return 32'(lg_rob[i]);
        return 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] lg_dj_at(input int i);
        if (i < lg_dj.size()) return lg_dj[i];
        return 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] lg_dk_at(input int i);
        if (i < lg_dk.size()) return lg_dk[i];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic lg_clear();
        lg_rob.delete(); lg_dj.delete(); lg_dk.delete();
    endtask

    // Compare process: DUT outputs against the model, mid-cycle
    int c_s;
    logic c_v;
    initial forever begin
        @(negedge clk_in);
        if (!rst_in) begin
            chk("rst_count", 32'(count), 0);
            chk("rst_full", 32'(dec_full), 0);
            chk("rst_valid", 32'(issue_valid), 0);
            chk("rst_rob", 32'(issue_rob_id), 0);
            chk("rst_dj", issue_data_j, 0);
        end else begin
            c_s = m_sel();
            c_v = rdy_in && !flush && (c_s >= 0);
            chk("count", 32'(count), 32'(mq.size()));
            chk("dec_full", 32'(dec_full), 32'(mq.size() == DEPTH));
            chk("issue_valid", 32'(issue_valid), 32'(c_v));
            if (c_v) begin
                chk("issue_rob_id", 32'(issue_rob_id), 32'(mq[c_s].rob));
                chk("issue_type", 32'(issue_type), 32'(mq[c_s].typ));
                chk("issue_data_j", issue_data_j, mq[c_s].dj);
                chk("issue_data_k", issue_data_k, mq[c_s].dk);
                chk("issue_imm", issue_imm, mq[c_s].imm);
            end
            if (issue_valid && issue_ready) begin
                lg_rob.push_back(issue_rob_id);
                lg_dj.push_back(issue_data_j);
                lg_dk.push_back(issue_data_k);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        dec_valid = 1'b0; bc_en = '0; flush = 1'b0;
        dec_pending_j = 1'b0; dec_pending_k = 1'b0;
    endtask

    task automatic ins(input logic [RW-1:0] rob,
                       input logic pj, input logic [RW-1:0] depj, input logic [DW-1:0] dj,
                       input logic pk, input logic [RW-1:0] depk, input logic [DW-1:0] dk);
        dec_valid = 1'b1; dec_rob_id = rob;
        dec_type = 5'(rob) + 5'd3;
        dec_imm = 32'hC0DE_0000 | 32'(rob);
        dec_pending_j = pj; dec_dep_j = depj; dec_data_j = dj;
        dec_pending_k = pk; dec_dep_k = depk; dec_data_k = dk;
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; issue_ready = 1'b0;
        dec_valid = 1'b0; dec_type = '0; dec_data_j = '0; dec_data_k = '0;
        dec_pending_j = 1'b0; dec_pending_k = 1'b0; dec_dep_j = '0; dec_dep_k = '0;
        dec_rob_id = '0; dec_imm = '0; bc_en = '0; bc_rob_id = '0; bc_data = '0;
        tick(); tick();
        rst_in = 1'b1;
        tick();

        // 1: three ready ops issue in order on consecutive cycles
        lg_clear();
        issue_ready = 1'b1;
        ins(4'd1, 0, 0, 32'h101, 0, 0, 32'h201); tick();
        ins(4'd2, 0, 0, 32'h102, 0, 0, 32'h202); tick();
        ins(4'd3, 0, 0, 32'h103, 0, 0, 32'h203); tick();
        idle(); tick(); tick();
        chk("t1_n", 32'(lg_rob.size()), 3);
        chk("t1_0", lg_rob_at(0), 1);
        chk("t1_1", lg_rob_at(1), 2);
        chk("t1_2", lg_rob_at(2), 3);
        chk("t1_count", 32'(count), 0);

        // 2: younger ready op issues before older one still waiting; then woken one issues
        lg_clear();
        issue_ready = 1'b0;
        ins(4'd5, 1, 4'd2, 32'h0, 0, 0, 32'h50); tick();
        ins(4'd6, 0, 0, 32'h60, 0, 0, 32'h61); tick();
        idle(); tick();
        bc_en = 2'b10; bc_rob_id = {4'd2, 4'd0}; bc_data = {32'hDEAD, 32'h0};
        issue_ready = 1'b1; tick();
        idle(); tick(); tick();
        chk("t2_n", 32'(lg_rob.size()), 2);
        chk("t2_0", lg_rob_at(0), 6);
        chk("t2_1", lg_rob_at(1), 5);
        chk("t2_dj", lg_dj_at(1), 32'hDEAD);

        // 3a: same-cycle capture at insert, issue next cycle
        lg_clear();
        ins(4'd8, 1, 4'd7, 32'h0, 0, 0, 32'h80);
        bc_en = 2'b01; bc_rob_id = {4'd0, 4'd7}; bc_data = {32'h0, 32'h1234}; tick();
        idle(); tick();
        chk("t3a_n", 32'(lg_rob.size()), 1);
        chk("t3a_dj", lg_dj_at(0), 32'h1234);
        // 3b: both ports match at insert, port 0 wins
        lg_clear();
        ins(4'd9, 0, 0, 32'h90, 1, 4'd7, 32'h0);
        bc_en = 2'b11; bc_rob_id = {4'd7, 4'd7}; bc_data = {32'h2, 32'h1}; tick();
        idle(); tick();
        chk("t3b_dk", lg_dk_at(0), 32'h1);
        // 3c: both ports match at wakeup, port 0 wins, issue the cycle after
        lg_clear();
        issue_ready = 1'b0;
        ins(4'd10, 1, 4'd4, 32'h0, 0, 0, 32'hA0); tick();
        idle(); tick();
        bc_en = 2'b11; bc_rob_id = {4'd4, 4'd4}; bc_data = {32'h22, 32'h11};
        issue_ready = 1'b1; tick();
        idle(); tick();
        chk("t3c_dj", lg_dj_at(0), 32'h11);

        // 4: fill, drop at full, issue with simultaneous insert at full and full-1
        lg_clear();
        issue_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ins(4'(i), 0, 0, 32'(i) + 32'h400, 0, 0, 32'h500); tick();
        end
        chk("t4_full", 32'(dec_full), 1);
        chk("t4_count8", 32'(count), 8);
        ins(4'd15, 0, 0, 32'hF, 0, 0, 32'hF); tick();
        chk("t4_drop", 32'(count), 8);
        issue_ready = 1'b1; tick();
        chk("t4_count7", 32'(count), 7);
        chk("t4_notfull", 32'(dec_full), 0);
        ins(4'd14, 0, 0, 32'hE, 0, 0, 32'hE); tick();
        chk("t4_swap", 32'(count), 7);
        idle();
        for (int c = 0; c < 20 && count != 0; c++) tick();
        chk("t4_drain", 32'(count), 0);
        chk("t4_n", 32'(lg_rob.size()), 9);
        for (int i = 0; i < 8; i++) chk("t4_ord", lg_rob_at(i), 32'(i));
        chk("t4_last", lg_rob_at(8), 14);

        // 5: flush beats insert and issue
        lg_clear();
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ins(4'(i), 0, 0, 32'h700, 0, 0, 32'h701); tick();
        end
        chk("t5_count5", 32'(count), 5);
        ins(4'd9, 0, 0, 32'h9, 0, 0, 32'h9);
        flush = 1'b1; issue_ready = 1'b1; tick();
        idle();
        chk("t5_count0", 32'(count), 0);
        chk("t5_noissue", 32'(lg_rob.size()), 0);
        ins(4'd11, 0, 0, 32'hB1, 0, 0, 32'hB2); tick();
        idle(); tick();
        chk("t5_after", lg_rob_at(0), 11);

        // 6: rdy_in low freezes issue and ignores broadcast
        lg_clear();
        issue_ready = 1'b0;
        ins(4'd12, 0, 0, 32'hAA, 0, 0, 32'hAB); tick();
        ins(4'd13, 1, 4'd3, 32'h0, 0, 0, 32'hD0); tick();
        idle();
        rdy_in = 1'b0; issue_ready = 1'b1;
        bc_en = 2'b01; bc_rob_id = {4'd0, 4'd3}; bc_data = {32'h0, 32'h55};
        tick(); tick(); tick();
        chk("t6_frozen", 32'(lg_rob.size()), 0);
        rdy_in = 1'b1; bc_en = '0; tick(); tick();
        chk("t6_n", 32'(lg_rob.size()), 1);
        chk("t6_rob", lg_rob_at(0), 12);
        chk("t6_dj", lg_dj_at(0), 32'hAA);
        chk("t6_count", 32'(count), 1);
        bc_en = 2'b01; bc_rob_id = {4'd0, 4'd3}; bc_data = {32'h0, 32'h77}; tick();
        idle(); tick();
        chk("t6_rob2", lg_rob_at(1), 13);
        chk("t6_dj2", lg_dj_at(1), 32'h77);

        // 7: asynchronous reset mid-operation
        issue_ready = 1'b0;
        ins(4'd1, 0, 0, 32'h1, 0, 0, 32'h1); tick();
        ins(4'd2, 0, 0, 32'h2, 0, 0, 32'h2); tick();
        idle();
        chk("t7_pre", 32'(count), 2);
        #2 rst_in = 1'b0;
        #1;
        chk("t7_count", 32'(count), 0);
        chk("t7_valid", 32'(issue_valid), 0);
        tick();
        rst_in = 1'b1;
        tick();
        chk("t7_after", 32'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
